// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcodes,
// operand-select codes and the idle/fetch select bundle.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_SUBI  = 3'b011;
    localparam logic [2:0] OP_AUIPC = 3'b100;
    localparam logic [2:0] OP_BRREL = 3'b101;

    localparam logic [1:0] SEL_REG0 = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_PC   = 2'd2;
    localparam logic [1:0] SEL_REG1 = 2'd3;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    typedef struct packed {
        logic       alu_mode;
        logic [1:0] num1_cs;
        logic [1:0] num2_cs;
    } alu_sel_t;

    // Operand selects presented whenever no instruction is being executed.
    localparam alu_sel_t SEL_IDLE = '{alu_mode: MODE_ADD, num1_cs: SEL_REG0, num2_cs: SEL_REG0};

    function automatic alu_sel_t make_sel(input logic mode, input logic [1:0] n1, input logic [1:0] n2);
        alu_sel_t s;
        s.alu_mode = mode;
        s.num1_cs  = n1;
        s.num2_cs  = n2;
        return s;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: ALU mode, operand selects, writeback target
// and illegal-opcode flag.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op,
    output logic       alu_mode,
    output logic [1:0] num1_cs,
    output logic [1:0] num2_cs,
    output logic       wr_reg,
    output logic       wr_pc,
    output logic       illegal
);

    alu_sel_t sel;

    always_comb begin
        sel     = SEL_IDLE;
        wr_reg  = 1'b0;
        wr_pc   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                sel    = make_sel(MODE_ADD, SEL_REG0, SEL_REG1);
                wr_reg = 1'b1;
            end
            OP_SUB: begin
                sel    = make_sel(MODE_SUB, SEL_REG0, SEL_REG1);
                wr_reg = 1'b1;
            end
            OP_ADDI: begin
                sel    = make_sel(MODE_ADD, SEL_REG0, SEL_IMM);
                wr_reg = 1'b1;
            end
            OP_SUBI: begin
                sel    = make_sel(MODE_SUB, SEL_REG0, SEL_IMM);
                wr_reg = 1'b1;
            end
            OP_AUIPC: begin
                sel    = make_sel(MODE_ADD, SEL_PC, SEL_IMM);
                wr_reg = 1'b1;
            end
            OP_BRREL: begin
                sel   = make_sel(MODE_ADD, SEL_PC, SEL_IMM);
                wr_pc = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_mode = sel.alu_mode;
    assign num1_cs  = sel.num1_cs;
    assign num2_cs  = sel.num2_cs;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state instruction sequencer (IDLE/FETCH/EXEC/WB) that drives ALU
// operand selects and register/PC write strobes, with stall and abort.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            hold,
    output logic            ready,
    output logic            ir_we,
    output logic            alu_mode,
    output logic [1:0]      num1_cs,
    output logic [1:0]      num2_cs,
    output logic            reg_we,
    output logic            pc_we,
    output logic            done,
    output logic            err
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            ir_we_q, ir_we_d;
    logic            reg_we_q, reg_we_d;
    logic            pc_we_q, pc_we_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            mode_q, mode_d;
    logic [1:0]      num1_q, num1_d;
    logic [1:0]      num2_q, num2_d;

    logic            dec_mode;
    logic [1:0]      dec_num1;
    logic [1:0]      dec_num2;
    logic            dec_wr_reg;
    logic            dec_wr_pc;
    logic            dec_illegal;

    alu_op_decode u_decode (
        .op       (op_q),
        .alu_mode (dec_mode),
        .num1_cs  (dec_num1),
        .num2_cs  (dec_num2),
        .wr_reg   (dec_wr_reg),
        .wr_pc    (dec_wr_pc),
        .illegal  (dec_illegal)
    );

    // Next-state and next-output logic; a stall freezes every register so the
    // pending strobe reappears exactly once when hold drops.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ir_we_d  = 1'b0;
        reg_we_d = 1'b0;
        pc_we_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mode_d   = SEL_IDLE.alu_mode;
        num1_d   = SEL_IDLE.num1_cs;
        num2_d   = SEL_IDLE.num2_cs;
        if (hold) begin
            ir_we_d  = ir_we_q;
            reg_we_d = reg_we_q;
            pc_we_d  = pc_we_q;
            done_d   = done_q;
            err_d    = err_q;
            mode_d   = mode_q;
            num1_d   = num1_q;
            num2_d   = num2_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        op_d    = op;
                        ir_we_d = 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_EXEC;
                    mode_d  = dec_mode;
                    num1_d  = dec_num1;
                    num2_d  = dec_num2;
                end
                ST_EXEC: begin
                    if (dec_illegal) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_WB;
                        mode_d   = dec_mode;
                        num1_d   = dec_num1;
                        num2_d   = dec_num2;
                        reg_we_d = dec_wr_reg;
                        pc_we_d  = dec_wr_pc;
                        done_d   = 1'b1;
                    end
                end
                ST_WB: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            ir_we_q  <= 1'b0;
            reg_we_q <= 1'b0;
            pc_we_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= SEL_IDLE.alu_mode;
            num1_q   <= SEL_IDLE.num1_cs;
            num2_q   <= SEL_IDLE.num2_cs;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ir_we_q  <= ir_we_d;
            reg_we_q <= reg_we_d;
            pc_we_q  <= pc_we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
        end
    end

    // Strobes are gated by hold so a stalled cycle never performs a write.
    assign ready    = (state_q == ST_IDLE) && !hold;
    assign ir_we    = ir_we_q  && !hold;
    assign reg_we   = reg_we_q && !hold;
    assign pc_we    = pc_we_q  && !hold;
    assign done     = done_q   && !hold;
    assign err      = err_q    && !hold;
    assign alu_mode = mode_q;
    assign num1_cs  = num1_q;
    assign num2_cs  = num2_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: per-scenario tasks with a scoreboard
// of expected completions popped when done or err appears.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic       hold;
    logic       ready;
    logic       ir_we;
    logic       alu_mode;
    logic [1:0] num1_cs;
    logic [1:0] num2_cs;
    logic       reg_we;
    logic       pc_we;
    logic       done;
    logic       err;

    typedef struct packed {
        logic       mode;
        logic [1:0] c1;
        logic [1:0] c2;
        logic       rw;
        logic       pw;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [10:0] IDLE_V  = {1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 4'b0000};
    localparam logic [10:0] FETCH_V = {1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'b0000};
    localparam logic [10:0] STROBES = 11'b11_0_00_00_1111;

    alu_seq_ctrl #(.OP_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .hold     (hold),
        .ready    (ready),
        .ir_we    (ir_we),
        .alu_mode (alu_mode),
        .num1_cs  (num1_cs),
        .num2_cs  (num2_cs),
        .reg_we   (reg_we),
        .pc_we    (pc_we),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference behaviour of each opcode, independent of the design package.
    function automatic exp_t model(input logic [2:0] o);
        exp_t e;
        case (o)
            3'd0:    e = '{1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0};
            3'd1:    e = '{1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0};
            3'd2:    e = '{1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0};
            3'd3:    e = '{1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0};
            3'd4:    e = '{1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0};
            3'd5:    e = '{1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0};
            default: e = '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        endcase
        return e;
    endfunction

    function automatic logic [10:0] exec_vec(input exp_t e);
        return {1'b0, 1'b0, e.mode, e.c1, e.c2, 4'b0000};
    endfunction

    function automatic logic [10:0] wb_vec(input exp_t e);
        if (e.er)
            return {1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 4'b0001};
        return {1'b0, 1'b0, e.mode, e.c1, e.c2, e.rw, e.pw, 1'b1, 1'b0};
    endfunction

    function automatic logic [10:0] obs();
        return {ready, ir_we, alu_mode, num1_cs, num2_cs, reg_we, pc_we, done, err};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hold = 1'b0; op = 3'd0;
        sb.delete();
        repeat (2) @(negedge clk);
        tests++;
        if (obs() !== IDLE_V) begin
            fails++;
            $display("[TB] FAIL reset_active: got %b expected %b", obs(), IDLE_V);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        end
        @(negedge clk);
        tests++;
        if (obs() !== IDLE_V) begin
            fails++;
            $display("[TB] FAIL reset_release: got %b expected %b", obs(), IDLE_V);
        end
    endtask

    task automatic test_ops();
        for (int k = 0; k < 8; k++) begin
            logic [2:0]  o;
            exp_t        e;
            exp_t        p;
            logic [10:0] v;
            o = k[2:0];
            e = model(o);
            @(negedge clk);
            tests++;
            if (obs() !== IDLE_V) begin
                fails++;
                $display("[TB] FAIL ops_idle op=%0d: got %b expected %b", o, obs(), IDLE_V);
            end
            start = 1'b1; op = o;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0; op = ~o;
            tests++;
            if (obs() !== FETCH_V) begin
                fails++;
                $display("[TB] FAIL ops_fetch op=%0d: got %b expected %b", o, obs(), FETCH_V);
            end
            @(negedge clk);
            tests++;
            if (e.er) begin
                if ((obs() & STROBES) !== 11'd0) begin
                    fails++;
                    $display("[TB] FAIL ops_exec_strobes op=%0d: got %b expected strobes 0", o, obs());
                end
            end else if (obs() !== exec_vec(e)) begin
                fails++;
                $display("[TB] FAIL ops_exec op=%0d: got %b expected %b", o, obs(), exec_vec(e));
            end
            @(negedge clk);
            tests++;
            if (!(done === 1'b1 || err === 1'b1)) begin
                fails++;
                $display("[TB] FAIL ops_complete op=%0d: got %b expected done or err", o, obs());
            end else if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL ops_unexpected op=%0d: got %b expected no completion", o, obs());
            end else begin
                p = sb.pop_front();
                v = wb_vec(p);
                if (obs() !== v) begin
                    fails++;
                    $display("[TB] FAIL ops_wb op=%0d: got %b expected %b", o, obs(), v);
                end
            end
            @(negedge clk);
            tests++;
            if (obs() !== IDLE_V) begin
                fails++;
                $display("[TB] FAIL ops_ready op=%0d: got %b expected %b", o, obs(), IDLE_V);
            end
        end
    endtask

    task automatic test_stall();
        exp_t        e;
        exp_t        p;
        logic [10:0] v;
        e = model(3'd1);
        @(negedge clk);
        start = 1'b1; op = 3'd1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (obs() !== FETCH_V) begin
            fails++;
            $display("[TB] FAIL stall_fetch: got %b expected %b", obs(), FETCH_V);
        end
        @(negedge clk);
        tests++;
        if (obs() !== exec_vec(e)) begin
            fails++;
            $display("[TB] FAIL stall_exec: got %b expected %b", obs(), exec_vec(e));
        end
        hold = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (obs() !== exec_vec(e)) begin
                fails++;
                $display("[TB] FAIL stall_frozen cycle=%0d: got %b expected %b", c, obs(), exec_vec(e));
            end
        end
        hold = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL stall_done_n5: got %b expected done=1", obs());
        end else begin
            p = sb.pop_front();
            v = wb_vec(p);
            if (obs() !== v) begin
                fails++;
                $display("[TB] FAIL stall_wb: got %b expected %b", obs(), v);
            end
        end
        @(negedge clk);
        tests++;
        if (obs() !== IDLE_V) begin
            fails++;
            $display("[TB] FAIL stall_idle: got %b expected %b", obs(), IDLE_V);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; op = 3'd0;
        sb.push_back(model(3'd0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (obs() !== exec_vec(model(3'd0))) begin
            fails++;
            $display("[TB] FAIL abort_exec: got %b expected %b", obs(), exec_vec(model(3'd0)));
        end
        rst = 1'b1;
        sb.delete();
        #1;
        tests++;
        if (obs() !== IDLE_V) begin
            fails++;
            $display("[TB] FAIL abort_async: got %b expected %b", obs(), IDLE_V);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL abort_ready: got %b expected 1", ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (obs() !== IDLE_V) begin
                fails++;
                $display("[TB] FAIL abort_quiet cycle=%0d: got %b expected %b", c, obs(), IDLE_V);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  seq [3];
        exp_t        p;
        logic [10:0] v;
        seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd5;
        @(negedge clk);
        start = 1'b1; op = seq[0];
        sb.push_back(model(seq[0]));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tests++;
            case (k % 4)
                1: begin
                    if (obs() !== FETCH_V) begin
                        fails++;
                        $display("[TB] FAIL b2b_fetch k=%0d: got %b expected %b", k, obs(), FETCH_V);
                    end
                end
                2: begin
                    v = exec_vec(model(seq[(k - 1) / 4]));
                    if (obs() !== v) begin
                        fails++;
                        $display("[TB] FAIL b2b_exec k=%0d: got %b expected %b", k, obs(), v);
                    end
                end
                3: begin
                    if (done !== 1'b1 || sb.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL b2b_done k=%0d: got %b expected done=1", k, obs());
                    end else begin
                        p = sb.pop_front();
                        v = wb_vec(p);
                        if (obs() !== v) begin
                            fails++;
                            $display("[TB] FAIL b2b_wb k=%0d: got %b expected %b", k, obs(), v);
                        end
                    end
                end
                default: begin
                    if (obs() !== IDLE_V) begin
                        fails++;
                        $display("[TB] FAIL b2b_idle k=%0d: got %b expected %b", k, obs(), IDLE_V);
                    end
                    if (k < 12) begin
                        op = seq[k / 4];
                        sb.push_back(model(op));
                    end else begin
                        start = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic test_hold_start();
        logic [10:0] held;
        held = {1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 4'b0000};
        @(negedge clk);
        hold = 1'b1; start = 1'b1; op = 3'd0;
        #1;
        tests++;
        if (obs() !== held) begin
            fails++;
            $display("[TB] FAIL hold_ready: got %b expected %b", obs(), held);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (obs() !== held) begin
            fails++;
            $display("[TB] FAIL hold_ignore: got %b expected %b", obs(), held);
        end
        hold = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++;
        if (obs() !== IDLE_V) begin
            fails++;
            $display("[TB] FAIL hold_no_fetch: got %b expected %b", obs(), IDLE_V);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_ops();
        test_stall();
        test_abort();
        test_back_to_back();
        test_hold_start();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
